// File: rtl/screen_pkg.sv
// Shared screen geometry and scan FSM state encoding.
// Used by the scan reader, the 6502 display window and the display stage.
package screen_pkg;

  localparam int SCR_ADDR_WIDTH = 11;
  localparam int SCR_DATA_WIDTH = 8;
  localparam int SCR_COLS_LOG2  = 5;
  localparam int SCR_ROWS_LOG2  = 5;
  localparam int SCR_PIX_W      = 4;

  localparam logic [SCR_ADDR_WIDTH-1:0] SCR_BASE_ADDR = 11'h200;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN
  } scan_state_e;

endpackage

// File: rtl/screen_scan_reader_fifo.sv
// Two-entry registered FIFO holding tagged pixels between RAM and output.
// Push and pop in the same cycle keep the count unchanged, even when full.
module pix_skid_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count,
  output logic         empty
);

  logic [W-1:0] hd_q, hd_d;
  logic [W-1:0] tl_q, tl_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop && (cnt_q != 2'd0);
  assign push_ok = push && ((cnt_q != 2'd2) || pop_ok);

  assign head  = hd_q;
  assign count = cnt_q;
  assign empty = (cnt_q == 2'd0);

  // Next-state of the head/tail slots and occupancy.
  always_comb begin
    hd_d  = hd_q;
    tl_d  = tl_q;
    cnt_d = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          hd_d = push_data;
        end else begin
          tl_d = push_data;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        hd_d  = tl_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          hd_d = tl_q;
          tl_d = push_data;
        end else begin
          hd_d = push_data;
        end
      end
      2'b00: begin
      end
      default: begin
      end
    endcase
  end

  // Slot and count registers; reset flushes the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hd_q  <= '0;
      tl_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      hd_q  <= hd_d;
      tl_q  <= tl_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/screen_scan_reader.sv
// Screen RAM read-side scanner: streams one frame of colour indices in
// raster order, hiding the RAM read latency and output backpressure.
module screen_scan_reader
  import screen_pkg::*;
#(
  parameter int ADDR_WIDTH = SCR_ADDR_WIDTH,
  parameter int DATA_WIDTH = SCR_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = SCR_BASE_ADDR,
  parameter int COLS_LOG2 = SCR_COLS_LOG2,
  parameter int ROWS_LOG2 = SCR_ROWS_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [3:0]            pix_data,
  output logic [COLS_LOG2-1:0]  pix_x,
  output logic [ROWS_LOG2-1:0]  pix_y,
  output logic                  pix_last,
  output logic                  frame_done
);

  localparam int IDX_W = COLS_LOG2 + ROWS_LOG2;
  localparam int TAG_W = IDX_W + 1;
  localparam int PAY_W = SCR_PIX_W + TAG_W;
  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

  scan_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                  infl_q, infl_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic                  done_q, done_d;

  logic                  issue;
  logic                  pop;
  logic [1:0]            fifo_cnt;
  logic [1:0]            occ;
  logic                  fifo_empty;
  logic [PAY_W-1:0]      push_data;
  logic [PAY_W-1:0]      head;
  logic [SCR_PIX_W-1:0]  hd_data;
  logic [COLS_LOG2-1:0]  hd_x;
  logic [ROWS_LOG2-1:0]  hd_y;
  logic                  hd_last;
  logic                  unused_rdata;

  assign unused_rdata = &{1'b0, rdata};

  assign {hd_data, hd_x, hd_y, hd_last} = head;

  assign pix_valid  = !fifo_empty;
  assign pix_data   = hd_data;
  assign pix_x      = hd_x;
  assign pix_y      = hd_y;
  assign pix_last   = hd_last;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;

  assign pop = pix_valid && pix_ready;

  // The slot freed by this cycle's pop may be refilled, which keeps
  // the stream at one pixel per cycle while never overflowing.
  assign occ   = fifo_cnt - {1'b0, pop};
  assign issue = (state_q == S_SCAN) &&
                 ((occ + {1'b0, infl_q}) < 2'd2);

  assign raddr   = issue ? (BASE_ADDR + ADDR_WIDTH'(idx_q)) : raddr_q;
  assign raddr_d = raddr;
  assign infl_d  = issue;

  assign tag_d = {idx_q[COLS_LOG2-1:0],
                  idx_q[IDX_W-1:COLS_LOG2],
                  (idx_q == IDX_LAST)};

  assign push_data = {rdata[SCR_PIX_W-1:0], tag_q};

  // Scan FSM and issue index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end
      end
      S_SCAN: begin
        if (issue) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && hd_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, index, address hold, in-flight flag and tag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      raddr_q <= BASE_ADDR;
      infl_q  <= 1'b0;
      tag_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      raddr_q <= raddr_d;
      infl_q  <= infl_d;
      if (issue) begin
        tag_q <= tag_d;
      end
      done_q  <= done_d;
    end
  end

  pix_skid_fifo #(
    .W (PAY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (infl_q),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_cnt),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_screen_scan_reader.sv
// Directed bench for screen_scan_reader with behavioural screen RAMs.
// Second instance uses a base address near the top of RAM.
module tb_screen_scan_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        pix_ready = 1'b0;
  logic        pix_ready2 = 1'b0;
  logic        busy, busy2;
  logic        pix_valid, pix_valid2;
  logic        pix_last, pix_last2;
  logic        frame_done, frame_done2;
  logic [10:0] raddr, raddr2;
  logic [7:0]  rdata, rdata2;
  logic [3:0]  pix_data, pix_data2;
  logic [4:0]  pix_x, pix_y, pix_x2, pix_y2;
  logic [7:0]  mem  [2048];
  logic [7:0]  mem2 [2048];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdata  <= mem[raddr];
    rdata2 <= mem2[raddr2];
  end

  screen_scan_reader dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .raddr(raddr), .rdata(rdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_last(pix_last), .frame_done(frame_done)
  );

  screen_scan_reader #(.BASE_ADDR(11'h7F0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2),
    .raddr(raddr2), .rdata(rdata2),
    .pix_valid(pix_valid2), .pix_ready(pix_ready2),
    .pix_data(pix_data2), .pix_x(pix_x2), .pix_y(pix_y2),
    .pix_last(pix_last2), .frame_done(frame_done2)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #5;
    n_cmp++; if (raddr !== 11'h200) begin n_bad++; $display("FAIL rst_raddr got %h want 200", raddr); end
    n_cmp++; if (raddr2 !== 11'h7F0) begin n_bad++; $display("FAIL rst_raddr2 got %h want 7f0", raddr2); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", pix_valid); end
    n_cmp++; if ({pix_data, pix_x, pix_y, pix_last} !== 15'd0) begin n_bad++; $display("FAIL rst_pix got %h/%0d/%0d/%b want 0", pix_data, pix_x, pix_y, pix_last); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", frame_done); end
    @(posedge clk); #1 rst = 1'b0; #4;
    n_cmp++; if (busy !== 1'b0 || pix_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_idle got busy=%b valid=%b want 0/0", busy, pix_valid); end
  endtask

  task automatic test_full_frame();
    int k, fd, last_c;
    k = 0; fd = 0; last_c = -10;
    pix_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1; #4;
    @(posedge clk); #1 start = 1'b0; #4;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ff_busy_c1 got %b want 1", busy); end
    n_cmp++; if (raddr !== 11'h200) begin n_bad++; $display("FAIL ff_raddr_c1 got %h want 200", raddr); end
    @(posedge clk); #5;
    n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL ff_valid_c2 got %b want 0", pix_valid); end
    for (int c = 3; c < 1200; c++) begin
      @(posedge clk); #5;
      if (c == 3) begin
        n_cmp++; if (pix_valid !== 1'b1) begin n_bad++; $display("FAIL ff_valid_c3 got %b want 1", pix_valid); end
      end
      if (frame_done === 1'b1) begin
        fd++;
        n_cmp++; if (c != last_c + 1) begin n_bad++; $display("FAIL ff_done_cycle got %0d want %0d", c, last_c + 1); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ff_busy_done got %b want 0", busy); end
      end
      if (pix_valid === 1'b1) begin
        n_cmp++;
        if ({pix_data, pix_x, pix_y, pix_last} !== {4'(k), 5'(k % 32), 5'(k / 32), (k == 1023)}) begin
          n_bad++;
          $display("FAIL ff_pix%0d got %h/%0d/%0d/%b want %h/%0d/%0d/%b", k, pix_data, pix_x, pix_y, pix_last, 4'(k), k % 32, k / 32, k == 1023);
        end
        if (pix_last === 1'b1) last_c = c;
        k++;
      end
      if (fd > 0 && c > last_c + 3) break;
    end
    n_cmp++; if (k != 1024) begin n_bad++; $display("FAIL ff_count got %0d want 1024", k); end
    n_cmp++; if (fd != 1) begin n_bad++; $display("FAIL ff_done_pulses got %0d want 1", fd); end
    n_cmp++; if (last_c != 1026) begin n_bad++; $display("FAIL ff_last_cycle got %0d want 1026", last_c); end
  endtask

  task automatic test_random_ready();
    int k, fd;
    logic stalled;
    logic [14:0] snap;
    k = 0; fd = 0; stalled = 1'b0; snap = '0;
    pix_ready = 1'b0;
    @(posedge clk); #1 start = 1'b1; #4;
    for (int c = 1; c < 6000; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      pix_ready = 1'($urandom_range(0, 1));
      #4;
      if (stalled) begin
        n_cmp++;
        if (pix_valid !== 1'b1 || {pix_data, pix_x, pix_y, pix_last} !== snap) begin
          n_bad++;
          $display("FAIL rr_stable got v=%b %h want v=1 %h", pix_valid, {pix_data, pix_x, pix_y, pix_last}, snap);
        end
      end
      if (frame_done === 1'b1) fd++;
      if (pix_valid === 1'b1 && pix_ready) begin
        n_cmp++;
        if ({pix_data, pix_x, pix_y, pix_last} !== {4'(k), 5'(k % 32), 5'(k / 32), (k == 1023)}) begin
          n_bad++;
          $display("FAIL rr_pix%0d got %h/%0d/%0d/%b", k, pix_data, pix_x, pix_y, pix_last);
        end
        k++;
      end
      stalled = (pix_valid === 1'b1) && !pix_ready;
      snap = {pix_data, pix_x, pix_y, pix_last};
      if (fd > 0) break;
    end
    pix_ready = 1'b1;
    n_cmp++; if (k != 1024) begin n_bad++; $display("FAIL rr_count got %0d want 1024", k); end
    n_cmp++; if (fd != 1) begin n_bad++; $display("FAIL rr_done got %0d want 1", fd); end
  endtask

  task automatic test_stall();
    int k, fd;
    k = 0; fd = 0;
    pix_ready = 1'b0;
    @(posedge clk); #1 start = 1'b1; #4;
    for (int c = 1; c < 20; c++) begin
      @(posedge clk); #1 start = 1'b0; #4;
      if (c >= 5) begin
        n_cmp++;
        if (pix_valid !== 1'b1 || {pix_data, pix_x, pix_y, pix_last} !== 15'd0 || raddr !== 11'h201) begin
          n_bad++;
          $display("FAIL st_hold c%0d got v=%b %h raddr=%h want v=1 0 raddr=201", c, pix_valid, {pix_data, pix_x, pix_y, pix_last}, raddr);
        end
      end
    end
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1 pix_ready = 1'b1; #4;
      if (frame_done === 1'b1) begin fd++; break; end
      if (pix_valid === 1'b1) begin
        n_cmp++;
        if ({pix_data, pix_x, pix_y, pix_last} !== {4'(k), 5'(k % 32), 5'(k / 32), (k == 1023)}) begin
          n_bad++;
          $display("FAIL st_pix%0d got %h/%0d/%0d/%b", k, pix_data, pix_x, pix_y, pix_last);
        end
        k++;
      end
    end
    n_cmp++; if (k != 1024 || fd != 1) begin n_bad++; $display("FAIL st_count got %0d/%0d want 1024/1", k, fd); end
  endtask

  task automatic test_wrap();
    int k, a;
    logic [3:0] exp_d;
    k = 0;
    pix_ready2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b1; #4;
    @(posedge clk); #1 start2 = 1'b0; #4;
    n_cmp++; if (raddr2 !== 11'h7F0 || busy2 !== 1'b1) begin n_bad++; $display("FAIL wr_first got %h/%b want 7f0/1", raddr2, busy2); end
    for (int c = 2; c < 1500; c++) begin
      @(posedge clk); #5;
      if (c == 16) begin
        n_cmp++; if (raddr2 !== 11'h7FF) begin n_bad++; $display("FAIL wr_raddr15 got %h want 7ff", raddr2); end
      end
      if (c == 17) begin
        n_cmp++; if (raddr2 !== 11'h000) begin n_bad++; $display("FAIL wr_raddr16 got %h want 000", raddr2); end
      end
      if (frame_done2 === 1'b1) break;
      if (pix_valid2 === 1'b1) begin
        a = (32'h7F0 + k) & 32'h7FF;
        exp_d = 4'(a * 7 + 3);
        n_cmp++;
        if ({pix_data2, pix_x2, pix_y2} !== {exp_d, 5'(k % 32), 5'(k / 32)}) begin
          n_bad++;
          $display("FAIL wr_pix%0d got %h/%0d/%0d want %h/%0d/%0d", k, pix_data2, pix_x2, pix_y2, exp_d, k % 32, k / 32);
        end
        k++;
      end
    end
    n_cmp++; if (k != 1024) begin n_bad++; $display("FAIL wr_count got %0d want 1024", k); end
  endtask

  task automatic test_mid_reset();
    int k, fd;
    k = 0; fd = 0;
    pix_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1; #4;
    for (int c = 1; c < 1200 && k <= 500; c++) begin
      @(posedge clk); #1 start = 1'b0; #4;
      if (pix_valid === 1'b1) k++;
    end
    rst = 1'b1;
    #1;
    n_cmp++; if ({busy, pix_valid, frame_done} !== 3'b000 || raddr !== 11'h200) begin n_bad++; $display("FAIL mr_rst_ctl got %b%b%b raddr=%h want 000 200", busy, pix_valid, frame_done, raddr); end
    n_cmp++; if ({pix_data, pix_x, pix_y, pix_last} !== 15'd0) begin n_bad++; $display("FAIL mr_rst_pix got %h want 0", {pix_data, pix_x, pix_y, pix_last}); end
    repeat (2) @(posedge clk);
    #5;
    n_cmp++; if ({busy, pix_valid, pix_data, pix_x, pix_y, pix_last} !== 17'd0) begin n_bad++; $display("FAIL mr_rst_hold got %h want 0", {busy, pix_valid, pix_data, pix_x, pix_y, pix_last}); end
    @(posedge clk); #1 rst = 1'b0; #4;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #5;
      n_cmp++; if (pix_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mr_quiet c%0d got v=%b busy=%b want 0/0", c, pix_valid, busy); end
    end
    k = 0;
    @(posedge clk); #1 start = 1'b1; #4;
    for (int c = 1; c < 1200; c++) begin
      @(posedge clk); #1 start = 1'b0; #4;
      if (c == 3) begin
        n_cmp++; if (pix_valid !== 1'b1 || pix_data !== 4'd0) begin n_bad++; $display("FAIL mr_restart got v=%b d=%h want 1/0", pix_valid, pix_data); end
      end
      if (frame_done === 1'b1) begin fd++; break; end
      if (pix_valid === 1'b1) begin
        n_cmp++;
        if ({pix_data, pix_x, pix_y, pix_last} !== {4'(k), 5'(k % 32), 5'(k / 32), (k == 1023)}) begin
          n_bad++;
          $display("FAIL mr_pix%0d got %h/%0d/%0d/%b", k, pix_data, pix_x, pix_y, pix_last);
        end
        k++;
      end
    end
    n_cmp++; if (k != 1024 || fd != 1) begin n_bad++; $display("FAIL mr_count got %0d/%0d want 1024/1", k, fd); end
  endtask

  task automatic test_back_to_back();
    int k, fr, cyc;
    k = 0; fr = 0; cyc = 0;
    pix_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1; #4;
    for (int c = 1; c < 3000 && fr < 2; c++) begin
      @(posedge clk); #1;
      start = (c == 300) || (frame_done === 1'b1 && fr == 0);
      #4;
      cyc++;
      if (frame_done === 1'b1) begin
        fr++;
        n_cmp++; if (k != 1024) begin n_bad++; $display("FAIL bb_frame%0d_count got %0d want 1024", fr, k); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bb_busy_done got %b want 0", busy); end
        k = 0;
        cyc = 0;
      end
      if (fr == 1 && cyc == 1) begin
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bb_restart_busy got %b want 1", busy); end
      end
      if (fr == 1 && cyc == 3) begin
        n_cmp++; if (pix_valid !== 1'b1 || pix_data !== 4'd0) begin n_bad++; $display("FAIL bb_restart_pix got v=%b d=%h want 1/0", pix_valid, pix_data); end
      end
      if (pix_valid === 1'b1) begin
        n_cmp++;
        if ({pix_data, pix_x, pix_y, pix_last} !== {4'(k), 5'(k % 32), 5'(k / 32), (k == 1023)}) begin
          n_bad++;
          $display("FAIL bb_pix%0d got %h/%0d/%0d/%b", k, pix_data, pix_x, pix_y, pix_last);
        end
        k++;
      end
    end
    start = 1'b0;
    n_cmp++; if (fr != 2) begin n_bad++; $display("FAIL bb_frames got %0d want 2", fr); end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) begin
      mem[a]  = 8'(a - 32'h200);
      mem2[a] = 8'(a * 7 + 3);
    end
    test_reset();
    test_full_frame();
    test_random_ready();
    test_stall();
    test_wrap();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
